bcd_share_arbiter: RTL and testbench

BCD_SHARE_ARBITER -- requirements
Module: bcd_share_arbiter

---
 rtl/bcd_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_bcd_share_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_share_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_share_arbiter
//   Two requesters share a single combinational binary-to-BCD converter.
//   A three-state FSM (IDLE -> LOAD -> RESP) grants one requester, registers
//   its operand, registers the converted result, then holds the result until
//   the owner consumes it. Operands above MAX_VALUE saturate to 16'h9999 and
//   set rsp_ovf.
//
//   Configuration macro: BCD_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, requester 0 wins ties, no last-grant state
//     undefined -> round-robin between the two requesters
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     req0/1_valid, req0/1_data operand offered by requester n
//     req0/1_ready              operand of requester n accepted this cycle
//     rsp0/1_valid, rsp0/1_ready result handshake for requester n
//     rsp_bcd, rsp_ovf          shared result (4 BCD digits) and saturation flag
// -----------------------------------------------------------------------------

// Combinational 16-bit binary to 4-digit packed BCD (shift-and-add-3).
// Values above 9999 lose the ten-thousands digit; the caller saturates those.
module binary2bcd (
   input  logic [15:0] data_in,
   output logic [15:0] data_out
);
   logic [31:0] sr;

   always_comb begin
      sr = {16'd0, data_in};
      for (int i = 0; i < 16; i++) begin
         for (int d = 0; d < 4; d++) begin
            if (sr[16+4*d +: 4] >= 4'd5)
               sr[16+4*d +: 4] = sr[16+4*d +: 4] + 4'd3;
         end
         sr = sr << 1;
      end
      data_out = sr[31:16];
   end
endmodule

module bcd_share_arbiter #(
   parameter int MAX_VALUE = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp_bcd,
   output logic        rsp_ovf
);
   localparam logic [15:0] MAX_V = 16'(MAX_VALUE);

   typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

   state_t      state_q, state_d;
   logic [15:0] operand_q, operand_d;
   logic        owner_q, owner_d;
   logic [15:0] rsp_bcd_q, rsp_bcd_d;
   logic        rsp_ovf_q, rsp_ovf_d;
   logic        gnt1;
   logic        sat;
   logic        rsp_taken;
   logic [15:0] conv_out;

`ifndef BCD_ARB_FIXED_PRIO_EN
   // Last requester granted; resets to 1 so requester 0 wins the first tie.
   logic        last_q, last_d;
`endif

   binary2bcd u_conv (
      .data_in  (operand_q),
      .data_out (conv_out)
   );

   // Grant selects requester 1 when it is alone, or on a tie when it was not
   // the last one served (round-robin only).
   always_comb begin
`ifdef BCD_ARB_FIXED_PRIO_EN
      gnt1 = req1_valid & ~req0_valid;
`else
      gnt1 = req1_valid & (~req0_valid | ~last_q);
`endif
   end

   // Handshake terms are gated by rst so they drop the instant reset rises.
   assign req0_ready = (state_q == IDLE) & ~rst & req0_valid & ~gnt1;
   assign req1_ready = (state_q == IDLE) & ~rst & gnt1;
   assign rsp0_valid = (state_q == RESP) & ~rst & ~owner_q;
   assign rsp1_valid = (state_q == RESP) & ~rst &  owner_q;

   assign sat       = operand_q > MAX_V;
   assign rsp_taken = owner_q ? rsp1_ready : rsp0_ready;
   assign rsp_bcd   = rsp_bcd_q;
   assign rsp_ovf   = rsp_ovf_q;

   always_comb begin
      state_d   = state_q;
      operand_d = operand_q;
      owner_d   = owner_q;
      rsp_bcd_d = rsp_bcd_q;
      rsp_ovf_d = rsp_ovf_q;
`ifndef BCD_ARB_FIXED_PRIO_EN
      last_d    = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0_ready | req1_ready) begin
               operand_d = gnt1 ? req1_data : req0_data;
               owner_d   = gnt1;
`ifndef BCD_ARB_FIXED_PRIO_EN
               last_d    = gnt1;
`endif
               state_d   = LOAD;
            end
         end
         LOAD: begin
            rsp_bcd_d = sat ? 16'h9999 : conv_out;
            rsp_ovf_d = sat;
            state_d   = RESP;
         end
         RESP: begin
            if (rsp_taken) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         operand_q <= '0;
         owner_q   <= 1'b0;
         rsp_bcd_q <= '0;
         rsp_ovf_q <= 1'b0;
`ifndef BCD_ARB_FIXED_PRIO_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         operand_q <= operand_d;
         owner_q   <= owner_d;
         rsp_bcd_q <= rsp_bcd_d;
         rsp_ovf_q <= rsp_ovf_d;
`ifndef BCD_ARB_FIXED_PRIO_EN
         last_q    <= last_d;
`endif
      end
   end
endmodule

// File: tb/tb_bcd_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_share_arbiter
//   Transaction-level model of the shared converter (busy flag, cycles since
//   acceptance, owner, decimal digits by division) checked against the DUT on
//   every falling edge, plus directed literal checks and a random phase.
// -----------------------------------------------------------------------------
module tb_bcd_share_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0, r0 = 1'b1, r1 = 1'b1;
   logic [15:0] d0 = '0, d1 = '0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_ovf;
   logic [15:0] rsp_bcd;

   int n_cmp = 0;
   int n_err = 0;

   bcd_share_arbiter #(.MAX_VALUE(9999)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_data(d0), .req0_ready(req0_ready),
      .req1_valid(v1), .req1_data(d1), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_ready(r0),
      .rsp1_valid(rsp1_valid), .rsp1_ready(r1),
      .rsp_bcd(rsp_bcd), .rsp_ovf(rsp_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // {ovf, bcd} from decimal digits of the operand
   function automatic logic [16:0] ref_conv(input int v);
      int b;
      if (v > 9999) return {1'b1, 16'h9999};
      b = ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
      return {1'b0, 16'(b)};
   endfunction

   // ---------------- reference model + per-cycle compare ----------------
   bit          m_busy = 0, m_owner = 0, m_last = 1, m_pov = 0, m_sov = 0;
   int          m_age = 0;
   logic [15:0] m_pend = '0, m_show = '0;

   always @(negedge clk) begin
      logic [16:0] cv;
      bit win1, e_r0, e_r1, e_v0, e_v1;
      if (rst) begin
         chk("rst_req0_ready", req0_ready, 0);
         chk("rst_req1_ready", req1_ready, 0);
         chk("rst_rsp0_valid", rsp0_valid, 0);
         chk("rst_rsp1_valid", rsp1_valid, 0);
         chk("rst_rsp_bcd", rsp_bcd, 0);
         chk("rst_rsp_ovf", rsp_ovf, 0);
         m_busy = 0; m_age = 0; m_last = 1; m_show = '0; m_sov = 0;
      end else begin
         if (v0 && v1) begin
`ifdef BCD_ARB_FIXED_PRIO_EN
            win1 = 0;
`else
            win1 = !m_last;
`endif
         end else begin
            win1 = v1;
         end
         e_r0 = !m_busy && v0 && !win1;
         e_r1 = !m_busy && v1 && win1;
         e_v0 = m_busy && m_age == 2 && !m_owner;
         e_v1 = m_busy && m_age == 2 && m_owner;
         chk("req0_ready", req0_ready, e_r0);
         chk("req1_ready", req1_ready, e_r1);
         chk("rsp0_valid", rsp0_valid, e_v0);
         chk("rsp1_valid", rsp1_valid, e_v1);
         chk("rsp_bcd", rsp_bcd, m_show);
         chk("rsp_ovf", rsp_ovf, m_sov);
         if (m_busy) begin
            if (m_age == 1) begin
               m_show = m_pend; m_sov = m_pov; m_age = 2;
            end else if (m_owner ? r1 : r0) begin
               m_busy = 0;
            end
         end else if (e_r0 || e_r1) begin
            cv = ref_conv(win1 ? int'(d1) : int'(d0));
            m_pend = cv[15:0]; m_pov = cv[16];
            m_owner = win1; m_last = win1; m_busy = 1; m_age = 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Advance one cycle; a valid accepted this cycle is dropped afterwards.
   task automatic cyc();
      bit hs0, hs1;
      #1;
      hs0 = v0 && req0_ready;
      hs1 = v1 && req1_ready;
      @(posedge clk);
      #1;
      if (hs0) v0 = 1'b0;
      if (hs1) v1 = 1'b0;
      #1;
   endtask

   task automatic do_req(input bit who, input int d, input int eb, input int eo, input bit lit);
      int t = 0;
      if (who) begin v1 = 1'b1; d1 = 16'(d); end
      else     begin v0 = 1'b1; d0 = 16'(d); end
      #1;
      while (!(who ? req1_ready : req0_ready) && t < 20) begin
         cyc();
         t++;
      end
      chk("grant_bounded", int'(t < 20), 1);
      if (lit) chk("grant_same_cycle", t, 0);
      cyc();
      cyc();
      if (lit) begin
         chk("lit_rsp_valid", who ? rsp1_valid : rsp0_valid, 1);
         chk("lit_rsp_bcd", rsp_bcd, eb);
         chk("lit_rsp_ovf", rsp_ovf, eo);
      end
      cyc();
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;

      // tie right after reset: requester 0 first
      d0 = 16'd7321; d1 = 16'd20; v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("tie0_req0_ready", req0_ready, 1);
      chk("tie0_req1_ready", req1_ready, 0);
      cyc();
      cyc();
      chk("tie0_rsp0_valid", rsp0_valid, 1);
      chk("tie0_rsp_bcd", rsp_bcd, 'h7321);
      v0 = 1'b1; d0 = 16'd7321;   // tie again while still in RESP
      cyc();
`ifdef BCD_ARB_FIXED_PRIO_EN
      chk("tie1_req0_ready", req0_ready, 1);
      cyc(); cyc();
      chk("tie1_rsp0_valid", rsp0_valid, 1);
      chk("tie1_rsp_bcd", rsp_bcd, 'h7321);
`else
      chk("tie1_req1_ready", req1_ready, 1);
      cyc(); cyc();
      chk("tie1_rsp1_valid", rsp1_valid, 1);
      chk("tie1_rsp_bcd", rsp_bcd, 'h0020);
`endif
      repeat (5) cyc();

      do_req(0, 255, 'h0255, 0, 1);
      do_req(1, 10000, 'h9999, 1, 1);
      do_req(1, 65535, 'h9999, 1, 1);
      do_req(1, 9999, 'h9999, 0, 1);

      // stalled response holds everything; req1 waits for the rsp0 handshake
      r0 = 1'b0; v0 = 1'b1; d0 = 16'd1234;
      cyc(); cyc();
      v1 = 1'b1; d1 = 16'd42;
      for (int i = 0; i < 10; i++) begin
         chk("stall_rsp0_valid", rsp0_valid, 1);
         chk("stall_rsp_bcd", rsp_bcd, 'h1234);
         chk("stall_req0_ready", req0_ready, 0);
         chk("stall_req1_ready", req1_ready, 0);
         cyc();
      end
      r0 = 1'b1;
      cyc();
      chk("stall_after_req1_ready", req1_ready, 1);
      cyc(); cyc();
      chk("stall_rsp1_bcd", rsp_bcd, 'h0042);
      cyc();

      // reset during LOAD aborts the transaction
      v0 = 1'b1; d0 = 16'd9;
      cyc();
      rst = 1'b1;
      #1;
      chk("rstload_rsp0_valid", rsp0_valid, 0);
      chk("rstload_rsp_bcd", rsp_bcd, 0);
      chk("rstload_req0_ready", req0_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("rstload_no_rsp", rsp0_valid, 0);
         cyc();
      end
      do_req(0, 1, 'h0001, 0, 1);

      // full sweep, alternating requesters
      for (int i = 0; i <= 9999; i++) do_req(i[0], i, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         d0 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
         d1 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         cyc();
      end
      v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
      repeat (5) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
